byte_packer: RTL and testbench

- Serial-to-parallel packer: accepts one 8-bit lane per beat and assembles LANES lanes into one 32-bit word.
- Inverse of the word splitter. Lane 0 lands in bits [7:0] and lane 3 in bits [31:24], so packer→splitter round-trips bit-exact.
- Sits between the byte-wide operand/result stream and the 32-bit word datapath of the vector multiplier.
- Valid/ready handshake on both sides; one-word output register gives full 1-byte/cycle throughput.

---
 rtl/vmul_pkg.sv | 10 +
 rtl/byte_packer_word_out_reg.sv | 27 ++
 rtl/byte_packer.sv | 71 +++++++
 tb/tb_byte_packer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmul_pkg.sv
// Shared lane/word geometry for the vector multiplier byte<->word path.
package vmul_pkg;
  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = LANE_W * LANES;
  localparam int CNT_W  = $clog2(LANES);

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/byte_packer_word_out_reg.sv
// One-word valid/ready holding register; a load may coincide with a drain.
module word_out_reg #(
  parameter int WORD_W = vmul_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              slot_free
);
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/byte_packer.sv
// Packs LANES byte beats into one word, lane 0 in the low byte.
// Optional BYTE_PACKER_FLUSH_EN adds a flush input that emits a zero-padded partial word.
module byte_packer
  import vmul_pkg::*;
#(
  parameter int LANE_W = vmul_pkg::LANE_W,
  parameter int LANES  = vmul_pkg::LANES
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef BYTE_PACKER_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic [LANE_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LANE_W*LANES-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(LANES)-1:0]  lane_cnt
);
  localparam int WW = LANE_W * LANES;
  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [WW-1:0] acc, merged;
  logic          slot_free, beat, last, complete, load;

  assign last     = (lane_cnt == LAST);
  assign in_ready = !last || slot_free;
  assign beat     = in_valid && in_ready;
  assign complete = beat && last;

  // Accumulator with this cycle's beat folded in; upper lanes are still zero.
  always_comb begin
    merged = acc;
    if (beat) merged[int'(lane_cnt)*LANE_W +: LANE_W] = in_data;
  end

`ifdef BYTE_PACKER_FLUSH_EN
  logic flush_go;
  assign flush_go = flush && slot_free && ((lane_cnt != '0) || beat) && !complete;
  assign load     = complete || flush_go;
`else
  assign load     = complete;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      lane_cnt <= '0;
    end else if (load) begin
      acc      <= '0;
      lane_cnt <= '0;
    end else if (beat) begin
      acc      <= merged;
      lane_cnt <= lane_cnt + CW'(1);
    end
  end

  word_out_reg #(.WORD_W(WW)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (merged),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .slot_free (slot_free)
  );
endmodule

// File: tb/tb_byte_packer.sv
// Directed + randomised-stall bench for byte_packer; flush scenarios when BYTE_PACKER_FLUSH_EN is set.
`timescale 1ns/1ps
module tb_byte_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  lane_cnt;
`ifdef BYTE_PACKER_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  byte_packer dut (
    .clk       (clk),
    .rst       (rst),
`ifdef BYTE_PACKER_FLUSH_EN
    .flush     (flush),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_cnt  (lane_cnt)
  );

  // Present one beat from a negedge and return at the negedge after it is taken.
  task automatic send_beat(input logic [7:0] d);
    int waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && waits < 50) begin
      @(negedge clk); #1; waits++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL beat_timeout data=%h in_ready=%b required 1", d, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({lane_cnt, out_valid, out_data, in_ready} !== {2'd0, 1'b0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got cnt=%0d ov=%b od=%h ir=%b required 0 0 00000000 1",
               lane_cnt, out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    send_beat(8'h11);
    n_checks++;
    if (lane_cnt !== 2'd1) begin n_fail++; $display("FAIL single_cnt1 got %0d required 1", lane_cnt); end
    send_beat(8'h22);
    send_beat(8'h33);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b required 0", out_valid); end
    send_beat(8'h44);
    n_checks++;
    if ({out_valid, out_data, lane_cnt} !== {1'b1, 32'h44332211, 2'd0}) begin
      n_fail++;
      $display("FAIL single_word got ov=%b od=%h cnt=%0d required 1 44332211 0", out_valid, out_data, lane_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle got ov=%b required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    int drops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (out_valid) got.push_back(out_data);
      in_valid = (i < 8);
      in_data  = 8'(i + 1);
      #1;
      if (i < 8 && !in_ready) drops++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (out_valid) got.push_back(out_data);
    n_checks++;
    if (drops != 0) begin n_fail++; $display("FAIL b2b_in_ready drops=%0d required 0", drops); end
    n_checks++;
    if (got.size() != 2) begin
      n_fail++; $display("FAIL b2b_count got %0d words required 2", got.size());
    end else begin
      n_checks++;
      if (got[0] !== 32'h04030201) begin n_fail++; $display("FAIL b2b_word0 got %h required 04030201", got[0]); end
      n_checks++;
      if (got[1] !== 32'h08070605) begin n_fail++; $display("FAIL b2b_word1 got %h required 08070605", got[1]); end
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    out_ready = 1'b0;
    send_beat(8'h10); send_beat(8'h11); send_beat(8'h12); send_beat(8'h13);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      #1;
      if (!in_ready || !out_valid || out_data !== 32'h13121110) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_hold bad=%0d required 0 (od=%h)", bad, out_data); end
    in_data = 8'hA3;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({in_ready, out_valid, out_data, lane_cnt} !== {1'b0, 1'b1, 32'h13121110, 2'd3}) begin
        n_fail++;
        $display("FAIL stall_block got ir=%b ov=%b od=%h cnt=%0d required 0 1 13121110 3",
                 in_ready, out_valid, out_data, lane_cnt);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got ir=%b required 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_data, lane_cnt} !== {1'b1, 32'hA3A2A1A0, 2'd0}) begin
      n_fail++;
      $display("FAIL stall_reload got ov=%b od=%h cnt=%0d required 1 a3a2a1a0 0", out_valid, out_data, lane_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got ov=%b required 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    send_beat(8'h21); send_beat(8'h22); send_beat(8'h23); send_beat(8'h24);
    send_beat(8'hDE); send_beat(8'hAD);
    n_checks++;
    if ({out_valid, lane_cnt} !== {1'b1, 2'd2}) begin
      n_fail++; $display("FAIL midrst_pre got ov=%b cnt=%0d required 1 2", out_valid, lane_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({out_valid, lane_cnt} !== {1'b0, 2'd0}) begin
      n_fail++; $display("FAIL midrst_clear got ov=%b cnt=%0d required 0 0", out_valid, lane_cnt);
    end
    out_ready = 1'b1;
    send_beat(8'h01); send_beat(8'h02); send_beat(8'h03); send_beat(8'h04);
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h04030201}) begin
      n_fail++; $display("FAIL midrst_word got ov=%b od=%h required 1 04030201", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    logic [31:0] words[1000];
    int wi = 0, li = 0, got = 0, cyc = 0, bad = 0;
    logic r;
    for (int i = 0; i < 1000; i++) words[i] = $urandom;
    while (got < 1000 && cyc < 40000) begin
      cyc++;
      r = ($urandom_range(0, 3) != 0);
      out_ready = r;
      if (out_valid && r) begin
        n_checks++;
        if (out_data !== words[got]) begin
          n_fail++; bad++;
          if (bad < 5) $display("FAIL rt_word idx=%0d got %h required %h", got, out_data, words[got]);
        end
        got++;
      end
      if (wi < 1000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = words[wi][li*8 +: 8];
      end else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        li++;
        if (li == 4) begin li = 0; wi++; end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got != 1000) begin n_fail++; $display("FAIL rt_timeout got %0d words required 1000", got); end
    @(negedge clk);
  endtask

`ifdef BYTE_PACKER_FLUSH_EN
  task automatic test_flush();
    int words = 0;
    out_ready = 1'b1;
    send_beat(8'h55); send_beat(8'h66);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if ({out_valid, out_data, lane_cnt} !== {1'b1, 32'h00006655, 2'd0}) begin
      n_fail++; $display("FAIL flush_partial got ov=%b od=%h cnt=%0d required 1 00006655 0", out_valid, out_data, lane_cnt);
    end
    @(negedge clk);
    flush = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got ov=%b required 0", out_valid); end
    end
    flush = 1'b0;
    send_beat(8'h01); send_beat(8'h02); send_beat(8'h03);
    in_valid = 1'b1; in_data = 8'h77; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h77030201}) begin
      n_fail++; $display("FAIL flush_final got ov=%b od=%h required 1 77030201", out_valid, out_data);
    end
    repeat (3) begin
      @(negedge clk);
      if (out_valid) words++;
    end
    n_checks++;
    if (words != 0) begin n_fail++; $display("FAIL flush_extra got %0d extra words required 0", words); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_round_trip();
`ifdef BYTE_PACKER_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
